// File: rtl/dmem_arb_pkg.sv
// Shared encodings and helpers for the data-memory arbiter.
// Imported by the top and the response-register sub-module.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rsp_reg.sv
// Per-port load response: one-cycle valid pulse plus held read data.
// Data is only replaced by the next accepted load on the same port.
module arb_rsp_reg
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_valid;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_valid <= i_load;
            if (i_load) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) and loader/debug (port 1).
// Registered ownership with a bounded burst so neither side starves.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int IDLE_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              req1_lock,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              core_stall
);

    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [1:0] IDLE_GNT =
        (IDLE_PRIO == PORT1) ? ST_OWN1 : ST_OWN0;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       w_other;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_own0;
    logic             w_own1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_own_v;
    logic             w_oth_v;
    logic             w_hold;

    assign w_own0  = (r_state == ST_OWN0);
    assign w_own1  = (r_state == ST_OWN1);
    assign w_acc0  = req0_valid & w_own0;
    assign w_acc1  = req1_valid & w_own1;
    assign w_own_v = w_own0 ? req0_valid : req1_valid;
    assign w_oth_v = w_own0 ? req1_valid : req0_valid;
    assign w_other = w_own0 ? ST_OWN1 : ST_OWN0;
    assign w_hold  = w_own1 & req1_lock;

    // Count includes the accept happening this cycle.
    assign w_cnt_inc = (r_cnt == MAX_CNT) ? MAX_CNT : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (req0_valid & req1_valid) begin
                    w_state_nxt = IDLE_GNT;
                end else if (req0_valid) begin
                    w_state_nxt = ST_OWN0;
                end else if (req1_valid) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_own_v) begin
                    w_state_nxt = w_oth_v ? w_other : ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if ((w_cnt_inc == MAX_CNT) & w_oth_v & ~w_hold) begin
                    w_state_nxt = w_other;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        if (w_own0) begin
            mem_address    = req0_addr;
            mem_write_data = req0_wdata;
        end else if (w_own1) begin
            mem_address    = req1_addr;
            mem_write_data = req1_wdata;
        end
    end

    assign req0_ready = w_own0;
    assign req1_ready = w_own1;
    assign mem_write  = (w_acc0 & req0_write) | (w_acc1 & req1_write);
    assign core_stall = req0_valid & ~req0_ready;

    arb_rsp_reg #(.DATA_W(DATA_W)) u_rsp0 (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_acc0 & ~req0_write),
        .i_rdata (mem_read_data),
        .o_valid (rsp0_valid),
        .o_rdata (rsp0_rdata)
    );

    arb_rsp_reg #(.DATA_W(DATA_W)) u_rsp1 (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_acc1 & ~req1_write),
        .i_rdata (mem_read_data),
        .o_valid (rsp1_valid),
        .o_rdata (rsp1_rdata)
    );

endmodule
